// File: rtl/debug_frame_loader.sv
// Debug link receive path: decodes UART bytes into request selects and
// instruction-memory load bursts (big-endian word count, MSB-first data).
//
// state  | meaning
// IDLE   | waiting for a command byte
// CNT_HI | waiting for high byte of the load word count
// CNT_LO | waiting for low byte of the load word count
// DATA   | assembling data bytes into words and writing them out
module debug_frame_loader #(
  parameter int NB_BYTE        = 8,
  parameter int NB_WORD        = 32,
  parameter int NB_ADDR        = 10,
  parameter int NB_COUNT       = 16,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [5:0]         o_request_select,
  output logic               o_request_valid,
  output logic [NB_WORD-1:0] o_mem_data,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic               o_mem_write,
  output logic               o_load_done,
  output logic               o_error
);

  localparam int BYTES_PER_WORD = NB_WORD / NB_BYTE;
  localparam int NB_IDX = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_IDX-1:0]     LAST_IDX = NB_IDX'(BYTES_PER_WORD - 1);
  localparam logic [NB_TIMEOUT-1:0] TO_LOAD  = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CNT_HI, CNT_LO, DATA} state_t;

  state_t                      state;
  logic [NB_IDX-1:0]           byte_idx;
  logic [NB_COUNT-1:0]         words_left;
  logic [NB_ADDR-1:0]          addr;
  logic [NB_TIMEOUT-1:0]       timer;
  logic [NB_BYTE-1:0]          cnt_hi;
  logic [NB_WORD-NB_BYTE-1:0]  partial;

  logic [1:0]          opcode;
  logic [NB_COUNT-1:0] count_next;
  logic [NB_WORD-1:0]  word_next;

  assign opcode     = i_rx_data[NB_BYTE-1 -: 2];
  assign count_next = NB_COUNT'({cnt_hi, i_rx_data});
  assign word_next  = {partial, i_rx_data};

  // timer is a down-counter reloaded on every accepted byte; reaching zero
  // with no byte in the same cycle is the inter-byte timeout
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= IDLE;
      byte_idx         <= '0;
      words_left       <= '0;
      addr             <= '0;
      timer            <= '0;
      cnt_hi           <= '0;
      partial          <= '0;
      o_request_select <= '0;
      o_request_valid  <= 1'b0;
      o_mem_data       <= '0;
      o_mem_addr       <= '0;
      o_mem_write      <= 1'b0;
      o_load_done      <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_request_valid <= 1'b0;
      o_mem_write     <= 1'b0;
      o_load_done     <= 1'b0;
      o_error         <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            case (opcode)
              2'b00: begin
                o_request_select <= i_rx_data[5:0];
                o_request_valid  <= 1'b1;
              end
              2'b01: begin
                state    <= CNT_HI;
                addr     <= '0;
                byte_idx <= '0;
                timer    <= TO_LOAD;
              end
              default: o_error <= 1'b1;
            endcase
          end
        end
        CNT_HI: begin
          if (i_rx_valid) begin
            cnt_hi <= i_rx_data;
            state  <= CNT_LO;
            timer  <= TO_LOAD;
          end else if (timer == '0) begin
            o_error <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        CNT_LO: begin
          if (i_rx_valid) begin
            if (count_next == '0) begin
              o_load_done <= 1'b1;
              state       <= IDLE;
            end else begin
              words_left <= count_next;
              byte_idx   <= '0;
              timer      <= TO_LOAD;
              state      <= DATA;
            end
          end else if (timer == '0) begin
            o_error <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (i_rx_valid) begin
            timer   <= TO_LOAD;
            partial <= word_next[NB_WORD-NB_BYTE-1:0];
            if (byte_idx == LAST_IDX) begin
              o_mem_write <= 1'b1;
              o_mem_data  <= word_next;
              o_mem_addr  <= addr;
              addr        <= addr + 1'b1;
              byte_idx    <= '0;
              if (words_left == NB_COUNT'(1)) begin
                o_load_done <= 1'b1;
                state       <= IDLE;
              end else begin
                words_left <= words_left - 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (timer == '0) begin
            o_error  <= 1'b1;
            byte_idx <= '0;
            state    <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_loader.sv
// Directed bench for debug_frame_loader: vector table plus hand-written
// timeout, wrap-around and mid-load reset sequences.
module tb_debug_frame_loader;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [5:0]  req_sel;
  logic        req_valid;
  logic [31:0] mem_data;
  logic [9:0]  mem_addr;
  logic        mem_write;
  logic        load_done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  debug_frame_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_request_select(req_sel), .o_request_valid(req_valid),
    .o_mem_data(mem_data), .o_mem_addr(mem_addr), .o_mem_write(mem_write),
    .o_load_done(load_done), .o_error(err)
  );

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        req;
    logic [5:0]  sel;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic rq, logic [5:0] s,
                              logic w, logic [9:0] a, logic [31:0] wd,
                              logic dn, logic e);
    vec_t r;
    r.valid = v; r.data = d; r.req = rq; r.sel = s; r.wr = w;
    r.addr = a; r.wdata = wd; r.done = dn; r.err = e;
    return r;
  endfunction

  function automatic vec_t byte_in(logic [7:0] d);
    return mk(1'b1, d, 1'b0, 6'h0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t idle_in();
    return mk(1'b0, 8'h0, 1'b0, 6'h0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t wr_in(logic [7:0] d, logic [9:0] a, logic [31:0] wd, logic dn);
    return mk(1'b1, d, 1'b0, 6'h0, 1'b1, a, wd, dn, 1'b0);
  endfunction

  function automatic vec_t req_in(logic [7:0] d, logic [5:0] s);
    return mk(1'b1, d, 1'b1, s, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t err_in(logic [7:0] d);
    return mk(1'b1, d, 1'b0, 6'h0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b1);
  endfunction

  // drive one cycle of input, then check the registered response #1 after the edge
  task automatic apply(input vec_t v, input string name);
    logic bad;
    @(negedge clk);
    rx_valid = v.valid;
    rx_data  = v.data;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    bad = (req_valid !== v.req) || (v.req && (req_sel !== v.sel)) ||
          (mem_write !== v.wr) ||
          (v.wr && ((mem_addr !== v.addr) || (mem_data !== v.wdata))) ||
          (load_done !== v.done) || (err !== v.err);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got req=%b sel=%h wr=%b addr=%h data=%h done=%b err=%b; want req=%b sel=%h wr=%b addr=%h data=%h done=%b err=%b",
               name, req_valid, req_sel, mem_write, mem_addr, mem_data, load_done, err,
               v.req, v.sel, v.wr, v.addr, v.wdata, v.done, v.err);
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (req_sel !== 6'h0 || req_valid !== 1'b0 || mem_data !== 32'h0 ||
        mem_addr !== 10'h0 || mem_write !== 1'b0 || load_done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got sel=%h req=%b data=%h addr=%h wr=%b done=%b err=%b; want all zero",
               name, req_sel, req_valid, mem_data, mem_addr, mem_write, load_done, err);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic logic [31:0] wrap_word(int w);
    logic [31:0] p;
    p = 32'h9E3779B9 * 32'(w + 1);
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int nwr;
    int last_addr;
    logic [31:0] w32;
    logic [7:0]  b8;

    tbl.push_back(req_in(8'h05, 6'h05));
    tbl.push_back(idle_in());
    tbl.push_back(byte_in(8'h40));
    tbl.push_back(byte_in(8'h00));
    tbl.push_back(byte_in(8'h02));
    tbl.push_back(byte_in(8'hDE));
    tbl.push_back(byte_in(8'hAD));
    tbl.push_back(byte_in(8'hBE));
    tbl.push_back(wr_in(8'hEF, 10'd0, 32'hDEADBEEF, 1'b0));
    tbl.push_back(byte_in(8'h01));
    tbl.push_back(byte_in(8'h02));
    tbl.push_back(byte_in(8'h03));
    tbl.push_back(wr_in(8'h04, 10'd1, 32'h01020304, 1'b1));
    tbl.push_back(idle_in());
    tbl.push_back(byte_in(8'h40));
    tbl.push_back(byte_in(8'h00));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 6'h0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0));
    tbl.push_back(err_in(8'hC3));
    tbl.push_back(req_in(8'h1F, 6'h1F));
    tbl.push_back(err_in(8'h80));
    tbl.push_back(req_in(8'h3F, 6'h3F));
    tbl.push_back(byte_in(8'h40));
    tbl.push_back(byte_in(8'h00));
    tbl.push_back(idle_in());
    tbl.push_back(byte_in(8'h01));
    tbl.push_back(byte_in(8'h11));
    tbl.push_back(idle_in());
    tbl.push_back(byte_in(8'h22));
    tbl.push_back(byte_in(8'h33));
    tbl.push_back(wr_in(8'h44, 10'd0, 32'h11223344, 1'b1));
    tbl.push_back(req_in(8'h05, 6'h05));

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // timeout with a partial word pending
    apply(byte_in(8'h40), "to_cmd");
    apply(byte_in(8'h00), "to_cnt_hi");
    apply(byte_in(8'h01), "to_cnt_lo");
    apply(byte_in(8'hAA), "to_d0");
    apply(byte_in(8'hBB), "to_d1");
    for (int c = 1; c <= TO; c++)
      apply(mk(1'b0, 8'h0, 1'b0, 6'h0, 1'b0, 10'h0, 32'h0, 1'b0, c == TO),
            $sformatf("to_wait%0d", c));
    apply(idle_in(), "to_after");
    apply(req_in(8'h05, 6'h05), "to_req");
    // fresh load after the abort: partial AA BB must not leak in
    apply(byte_in(8'h40), "post_to_cmd");
    apply(byte_in(8'h00), "post_to_hi");
    apply(byte_in(8'h01), "post_to_lo");
    apply(byte_in(8'h11), "post_to_d0");
    apply(byte_in(8'h22), "post_to_d1");
    apply(byte_in(8'h33), "post_to_d2");
    apply(wr_in(8'h44, 10'd0, 32'h11223344, 1'b1), "post_to_wr");

    // byte arriving exactly at the terminal count wins
    apply(byte_in(8'h40), "tc_cmd");
    apply(byte_in(8'h00), "tc_hi");
    apply(byte_in(8'h01), "tc_lo");
    for (int c = 1; c < TO; c++)
      apply(idle_in(), $sformatf("tc_wait%0d", c));
    apply(byte_in(8'hAA), "tc_byte");
    apply(byte_in(8'hBB), "tc_d1");
    apply(byte_in(8'hCC), "tc_d2");
    apply(wr_in(8'hDD, 10'd0, 32'hAABBCCDD, 1'b1), "tc_wr");

    // 1025 words back-to-back: address wraps to 0 on the last write
    apply(byte_in(8'h40), "wrap_cmd");
    apply(byte_in(8'h04), "wrap_hi");
    apply(byte_in(8'h01), "wrap_lo");
    nwr = 0;
    last_addr = -1;
    for (int w = 0; w < 1025; w++) begin
      w32 = wrap_word(w);
      for (int b = 0; b < 4; b++) begin
        b8 = w32[31 - 8*b -: 8];
        if (b == 3)
          apply(wr_in(b8, 10'(w), w32, w == 1024), $sformatf("wrap_w%0d", w));
        else
          apply(byte_in(b8), $sformatf("wrap_w%0d_b%0d", w, b));
        if (mem_write === 1'b1) begin
          nwr++;
          last_addr = int'(mem_addr);
        end
      end
    end
    check_int("wrap_write_count", nwr, 1025);
    check_int("wrap_last_addr", last_addr, 0);
    apply(req_in(8'h1F, 6'h1F), "wrap_req");

    // reset mid-word
    apply(byte_in(8'h40), "rst_cmd");
    apply(byte_in(8'h00), "rst_hi");
    apply(byte_in(8'h02), "rst_lo");
    apply(byte_in(8'hDE), "rst_d0");
    apply(byte_in(8'hAD), "rst_d1");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    apply(byte_in(8'hBE), "rst_hold0");
    apply(byte_in(8'hEF), "rst_hold1");
    apply(byte_in(8'h01), "rst_hold2");
    apply(byte_in(8'h02), "rst_hold3");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++)
      apply(idle_in(), $sformatf("rst_idle%0d", c));
    apply(req_in(8'h05, 6'h05), "rst_req");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_frame_loader.md
Name: debug_frame_loader

Overview:
- Host-to-MIPS half of the debug link: consumes bytes from the UART receiver and decodes them into debug commands.
- Request commands forward a 6-bit request select to the debug controllers. Per the existing select encoding, MSB=0 selects a regfile register and bits[4:0] give the register address.
- Load commands assemble MSB-first byte streams into words and write them sequentially into MIPS instruction memory.
- Sits between the UART RX and both the debug controllers and the instruction memory write port.

Parameters:
- NB_BYTE, 8, width of an incoming frame from the UART.
- NB_WORD, 32, width of an assembled memory word; must be a multiple of NB_BYTE.
- NB_ADDR, 10, instruction memory word-address width.
- NB_COUNT, 16, width of the word-count field of a load command.
- NB_TIMEOUT, 16, width of the inter-byte timeout counter.
- TIMEOUT_CYCLES, 50000, idle cycles allowed between bytes inside a command before abort.

Ports:
- i_clock  input  1  system clock, all logic on rising edge.
- i_reset  input  1  asynchronous, active-low reset (0 = reset).
- i_rx_data  input  NB_BYTE  received byte, valid only when i_rx_valid=1.
- i_rx_valid  input  1  one-cycle strobe per received byte.
- o_request_select  output  6  request select for debug controllers; held until next request command.
- o_request_valid  output  1  one-cycle pulse, new request select issued.
- o_mem_data  output  NB_WORD  assembled word; held until next write.
- o_mem_addr  output  NB_ADDR  word address for o_mem_data.
- o_mem_write  output  1  one-cycle write strobe to instruction memory.
- o_load_done  output  1  one-cycle pulse, load command completed.
- o_error  output  1  one-cycle pulse, command aborted (timeout or bad opcode).

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0; byte index, word counter, address and timeout counter all 0.
- Command byte: bits[NB_BYTE-1:NB_BYTE-2] are the opcode.
  - 00 = REQUEST: bits[5:0] are the select.
  - 01 = LOAD.
  - 10 and 11 = invalid.
- States: IDLE, CNT_HI, CNT_LO, DATA.
- IDLE, on i_rx_valid:
  - REQUEST: next cycle o_request_select=byte[5:0] and o_request_valid=1 for exactly one cycle; stay in IDLE.
  - LOAD: go to CNT_HI; clear address to 0 and byte index to 0.
  - Invalid opcode: o_error pulses next cycle; stay in IDLE.
- CNT_HI / CNT_LO: capture word count big-endian (high byte first); for NB_BYTE=8, NB_COUNT=16 the count is exactly two bytes.
  - After the CNT_LO byte, count=0: o_load_done pulses next cycle, return to IDLE, no writes.
  - Otherwise go to DATA.
- DATA:
  - Shift each byte into the word assembler MSB-first.
  - Byte index counts 0..NB_WORD/NB_BYTE-1.
  - On the last byte of a word, the next cycle has o_mem_write=1, o_mem_data=full word, o_mem_addr=current address.
  - Address increments by 1 after each write; wraps modulo 2^NB_ADDR without error.
  - Byte index returns to 0 after each word.
  - On the last word, o_load_done pulses in the same cycle as its o_mem_write; return to IDLE.
- Latency: 1 cycle from the i_rx_valid of the completing byte to the o_mem_write / o_request_valid / o_load_done / o_error pulse.
- Timeout:
  - Counter runs only in CNT_HI, CNT_LO and DATA.
  - Cleared on entering these states and on every i_rx_valid.
  - Reaching TIMEOUT_CYCLES: o_error pulses, partial word discarded (no write), state to IDLE.
  - If i_rx_valid and the timeout terminal count coincide, the byte wins and no error is raised.
  - No timeout in IDLE.
- Bytes arriving back-to-back on consecutive cycles must all be accepted; no backpressure exists.
- Reset asserted mid-load aborts immediately: no further writes, no o_load_done, no o_error.

Test Plan:
- Send 0x05 (REQUEST, select 5) -> one cycle later o_request_select=6'h05 and o_request_valid=1 for one cycle; no mem write.
- Send 0x40,0x00,0x02,0xDE,0xAD,0xBE,0xEF,0x01,0x02,0x03,0x04 ->
  - write addr 0 data 0xDEADBEEF;
  - write addr 1 data 0x01020304 with o_load_done in the same cycle;
  - state IDLE after.
- Send 0x40,0x00,0x00 -> o_load_done one cycle after the third byte, zero writes.
- Send 0x40,0x00,0x01,0xAA,0xBB then idle TIMEOUT_CYCLES -> o_error pulse, no o_mem_write; then 0x05 is accepted as a REQUEST.
- Send 0xC3 -> o_error pulse, state IDLE; a following 0x1F produces o_request_select=6'h1F.
- Load of 2^NB_ADDR+1 words, bytes driven every cycle -> the last write goes to addr 0 (wrap); all words written with no drops. Separately, pull i_reset low mid-word -> outputs 0 asynchronously, no write or done pulse afterwards.
